// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and helpers for the button popcount block
package button_pkg;

  // 10 ms of stable input at 25 MHz
  localparam int DEBOUNCE_DEFAULT = 250000;

  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - one button channel: invert, 2-FF sync, optional debounce
// Debouncer present only when BUTTON_POPCOUNT_DEBOUNCE_EN is defined.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_N,
  output logic STATE
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= ~BTN_N;
      s2_q <= s1_q;
    end
  end

`ifdef BUTTON_POPCOUNT_DEBOUNCE_EN
  localparam int DC_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);

  logic            st_q, st_d;
  logic [DC_W-1:0] dc_q, dc_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q <= 1'b0;
      dc_q <= '0;
    end else begin
      st_q <= st_d;
      dc_q <= dc_d;
    end
  end

  // Any sample agreeing with the stable state restarts the run.
  always_comb begin
    st_d = st_q;
    dc_d = '0;
    if (s2_q != st_q) begin
      if (dc_q == DC_LAST) begin
        st_d = s2_q;
      end else begin
        dc_d = dc_q + 1'b1;
      end
    end
  end

  assign STATE = st_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign STATE = s2_q;
`endif

endmodule

// File: rtl/button_popcount.sv
// rtl/button_popcount.sv - held-button popcount, change strobe and saturating press counter
// Optional per-channel debounce selected by BUTTON_POPCOUNT_DEBOUNCE_EN.
module button_popcount
  import button_pkg::*;
#(
  parameter int  N_BTN           = 3,
  parameter int  DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int  EVENT_W         = 8,
  localparam int CNT_W           = cnt_w(N_BTN)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_BTN-1:0]   PMOD,
  input  logic               CLEAR,
  output logic [CNT_W-1:0]   COUNT,
  output logic               CHANGED,
  output logic [EVENT_W-1:0] EVENTS
);

  localparam int SUM_W = ((EVENT_W > CNT_W) ? EVENT_W : CNT_W) + 1;
  localparam logic [EVENT_W-1:0] EV_MAX = '1;

  logic [N_BTN-1:0]   st;
  logic [N_BTN-1:0]   st_prev_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               changed_q, changed_d;
  logic [EVENT_W-1:0] events_q, events_d;
  logic [CNT_W-1:0]   presses;
  logic [SUM_W-1:0]   sum;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .CLK  (CLK),
      .RST_N(RST_N),
      .BTN_N(PMOD[g]),
      .STATE(st[g])
    );
  end

  always_comb begin
    count_d = '0;
    presses = '0;
    for (int i = 0; i < N_BTN; i++) begin
      count_d = count_d + CNT_W'(st[i]);
      presses = presses + CNT_W'(st[i] & ~st_prev_q[i]);
    end
    changed_d = (count_d != count_q);
    sum       = SUM_W'(events_q) + SUM_W'(presses);
    // Clear wins over any presses landing in the same cycle.
    if (CLEAR) begin
      events_d = '0;
    end else if (sum > SUM_W'(EV_MAX)) begin
      events_d = EV_MAX;
    end else begin
      events_d = sum[EVENT_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_prev_q <= '0;
      count_q   <= '0;
      changed_q <= 1'b0;
      events_q  <= '0;
    end else begin
      st_prev_q <= st;
      count_q   <= count_d;
      changed_q <= changed_d;
      events_q  <= events_d;
    end
  end

  assign COUNT   = count_q;
  assign CHANGED = changed_q;
  assign EVENTS  = events_q;

endmodule

// File: tb/tb_button_popcount.sv
// tb/tb_button_popcount.sv - self-checking bench for button_popcount
module tb_button_popcount;

  localparam int N   = 3;
  localparam int D   = 4;
  localparam int EW  = 3;
  localparam int EVMAX = (1 << EW) - 1;
`ifdef BUTTON_POPCOUNT_DEBOUNCE_EN
  localparam int LAT = 2 + D;
`else
  localparam int LAT = 2;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [N-1:0]  PMOD = 3'b000;
  logic          CLEAR = 1'b0;
  logic [1:0]    COUNT;
  logic          CHANGED;
  logic [EW-1:0] EVENTS;

  int n_checks = 0;
  int n_fail   = 0;

  button_popcount #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .EVENT_W(EW)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .PMOD   (PMOD),
    .CLEAR  (CLEAR),
    .COUNT  (COUNT),
    .CHANGED(CHANGED),
    .EVENTS (EVENTS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  // Model: a button's stable state follows the pressed level once that level
  // has been seen for D consecutive synchronised samples (or immediately
  // without debounce); outputs are the registered view of that stable state.
  bit         samp [N][D+2];
  logic [N-1:0] m_st, m_prev;
  int         m_count, m_events, m_rises;
  bit         m_changed, m_held;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_st = '0; m_prev = '0; m_count = 0; m_events = 0; m_changed = 0;
      for (int c = 0; c < N; c++)
        for (int j = 0; j < D + 2; j++) samp[c][j] = 1'b0;
    end else begin
      m_rises   = popc(m_st & ~m_prev);
      m_events  = CLEAR ? 0 : ((m_events + m_rises > EVMAX) ? EVMAX : m_events + m_rises);
      m_changed = (popc(m_st) != m_count);
      m_count   = popc(m_st);
      m_prev    = m_st;
      for (int c = 0; c < N; c++) begin
`ifdef BUTTON_POPCOUNT_DEBOUNCE_EN
        m_held = 1'b1;
        for (int j = 1; j <= D; j++) if (samp[c][j] == m_st[c]) m_held = 1'b0;
        if (m_held) m_st[c] = ~m_st[c];
`else
        m_st[c] = samp[c][0];
`endif
        for (int j = D + 1; j > 0; j--) samp[c][j] = samp[c][j-1];
        samp[c][0] = ~PMOD[c];
      end
    end
  end

  always @(negedge CLK) begin
    check("model_count", 32'(COUNT), 32'(m_count));
    check("model_changed", 32'(CHANGED), 32'(m_changed));
    check("model_events", 32'(EVENTS), 32'(m_events));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all buttons pressed
    tick(3);
    check("rst_count", 32'(COUNT), 0);
    check("rst_changed", 32'(CHANGED), 0);
    check("rst_events", 32'(EVENTS), 0);
    RST_N = 1'b1;
    tick(LAT);
    check("rel_count_early", 32'(COUNT), 0);
    tick(1);
    check("rel_count", 32'(COUNT), 3);
    check("rel_changed", 32'(CHANGED), 1);
    check("rel_events", 32'(EVENTS), 3);
    tick(1);
    check("rel_changed_once", 32'(CHANGED), 0);

    PMOD = 3'b111;
    tick(LAT + 2);
    check("idle_count", 32'(COUNT), 0);
    check("idle_events", 32'(EVENTS), 3);

    // Single press
    PMOD = 3'b110;
    tick(LAT);
    check("single_early", 32'(COUNT), 0);
    tick(1);
    check("single_count", 32'(COUNT), 1);
    check("single_changed", 32'(CHANGED), 1);
    check("single_events", 32'(EVENTS), 4);
    tick(1);
    check("single_changed_off", 32'(CHANGED), 0);
    PMOD = 3'b111;
    tick(LAT + 2);

    // Glitch shorter than the debounce window
    PMOD = 3'b101;
    tick(3);
    PMOD = 3'b111;
    for (int i = 0; i < LAT + 4; i++) begin
      tick(1);
`ifdef BUTTON_POPCOUNT_DEBOUNCE_EN
      check("glitch_count", 32'(COUNT), 0);
      check("glitch_changed", 32'(CHANGED), 0);
`endif
    end
`ifdef BUTTON_POPCOUNT_DEBOUNCE_EN
    check("glitch_events", 32'(EVENTS), 4);
`endif

    // Saturation
    for (int i = 0; i < 9; i++) begin
      PMOD = 3'b110;
      tick(LAT + 2);
      PMOD = 3'b111;
      tick(LAT + 2);
    end
    check("sat_events", 32'(EVENTS), 7);

    // Clear in the cycle a press lands
    PMOD = 3'b110;
    tick(LAT);
    CLEAR = 1'b1;
    tick(1);
    CLEAR = 1'b0;
    check("clr_events", 32'(EVENTS), 0);
    check("clr_count", 32'(COUNT), 1);
    check("clr_changed", 32'(CHANGED), 1);
    tick(1);
    check("clr_dropped", 32'(EVENTS), 0);
    PMOD = 3'b111;
    tick(LAT + 2);

    // Three together, then release two
    PMOD = 3'b000;
    tick(LAT);
    check("tri_early", 32'(EVENTS), 0);
    tick(1);
    check("tri_events", 32'(EVENTS), 3);
    check("tri_count", 32'(COUNT), 3);
    tick(2);
    PMOD = 3'b011;
    tick(LAT);
    check("drop_early", 32'(COUNT), 3);
    tick(1);
    check("drop_count", 32'(COUNT), 1);
    check("drop_changed", 32'(CHANGED), 1);
    check("drop_events", 32'(EVENTS), 3);
    tick(1);
    check("drop_changed_off", 32'(CHANGED), 0);

    // Asynchronous reset mid-press
    tick(2);
    #2 RST_N = 1'b0;
    #1;
    check("arst_count", 32'(COUNT), 0);
    check("arst_changed", 32'(CHANGED), 0);
    check("arst_events", 32'(EVENTS), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    PMOD = 3'b111;
    tick(LAT + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_popcount.md
# button_popcount

Parametrised successor to the three-button press counter. It samples `N_BTN` active-low push-button pins and synchronises them into the clock domain. Each channel is optionally debounced. The block drives a registered population count of currently-held buttons, a one-cycle change strobe, and a saturating counter of press events. It sits between the PMOD button header and the LED/display logic.

## Interface
Parameters:
- `N_BTN`, default 3: number of button channels; must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable samples required before a channel changes state; must be ≥ 1. Ignored when debounce is compiled out.
- `EVENT_W`, default 8: width of the press-event counter.
- `CNT_W`, derived, not overridable: `$clog2(N_BTN+1)`.

Ports:
- `CLK`, input, 1: single clock, rising-edge.
- `RST_N`, input, 1: asynchronous active-low reset.
- `PMOD`, input, `N_BTN`: raw button pins, active-low (0 = pressed), asynchronous to `CLK`.
- `CLEAR`, input, 1: synchronous clear of `EVENTS`, active-high.
- `COUNT`, output, `CNT_W`: number of buttons currently held (debounced).
- `CHANGED`, output, 1: one-cycle pulse when `COUNT` takes a new value.
- `EVENTS`, output, `EVENT_W`: saturating count of press events since reset or clear.

## Operation
- **Per-channel pipeline:**
  - Invert `PMOD` to obtain the pressed signal.
  - Pass it through a 2-FF synchronizer (`s1`, `s2`).
  - Feed `s2` to the debouncer, producing the stable state `st`.
- **Debouncer:**
  - Each channel has a counter `dc` of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2 == st`, then `dc <= 0`.
  - Otherwise, if `dc == DEBOUNCE_CYCLES-1`, then `st <= s2` and `dc <= 0`.
  - Otherwise, `dc <= dc+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` samples leaves `st` unchanged.
- **COUNT:** registered popcount of `st[N_BTN-1:0]`, zero-extended to `CNT_W`. It cannot overflow, because the maximum is `N_BTN`.
- **CHANGED:** asserted in the cycle where the newly registered `COUNT` differs from its previous value. It pulses once per update, even if the value moves by more than 1.
- **EVENTS:**
  - Each cycle, `presses` = the number of channels whose `st` rises 0→1 in that cycle (0..`N_BTN`).
  - `EVENTS <= min(EVENTS + presses, 2^EVENT_W - 1)`. It saturates and never wraps.
  - Releases (1→0) are not counted.
- **Simultaneous events:**
  - `CLEAR` takes priority: `EVENTS <= 0`, and any presses in that cycle are dropped.
  - `COUNT` and `CHANGED` are unaffected by `CLEAR`.
- **Reset (asynchronous, any time, including mid-debounce):**
  - `s1`, `s2`, `st`, `dc` go to 0.
  - `COUNT` = 0, `CHANGED` = 0, `EVENTS` = 0.
  - After `RST_N` deasserts, a button already held is treated as a new press and counts as an event once debounced.

## Timing
- Let t be the first rising edge that samples a new `PMOD` level.
- With debounce: `st` changes at edge t+1+`DEBOUNCE_CYCLES`. `COUNT` and `CHANGED` update at t+2+`DEBOUNCE_CYCLES`, and `EVENTS` updates at the same edge.
- Without debounce: `st` is `s2` (changes at t+1), and `COUNT`/`EVENTS` update at t+2.
- `CHANGED` stays high for exactly one cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `BUTTON_POPCOUNT_DEBOUNCE_EN`.
- Defined: the debouncer described above is instantiated per channel.
- Undefined: `st` is assigned directly from `s2`, no `dc` counters exist, `DEBOUNCE_CYCLES` is ignored, and latency is 2 cycles.

## Structure
- **Package `button_pkg`:**
  - `function automatic int cnt_w(int n)` returning `$clog2(n+1)`.
  - The default debounce constant `DEBOUNCE_DEFAULT` = 250000 (10 ms at 25 MHz).
- **Sub-module `button_debounce`:** one channel (synchronizer plus debouncer), instantiated `N_BTN` times with generate.
  - Ports: `CLK`, `RST_N`, `BTN_N`, `STATE`.
  - The `BUTTON_POPCOUNT_DEBOUNCE_EN` macro is honoured inside it.
- **Top level** holds the popcount, the `CHANGED` and `EVENTS` logic, and edge detection on `st`.

## Test plan
All scenarios use `N_BTN`=3, `DEBOUNCE_CYCLES`=4, `EVENT_W`=3.
- **Reset:** hold `PMOD`=3'b000 (all pressed) through reset, then release reset → after 6 edges `COUNT`=3, `CHANGED` pulses once, `EVENTS`=3.
- **Single press:** `PMOD` 3'b111→3'b110 at edge t → `COUNT`=1 and `CHANGED`=1 exactly at t+6; `EVENTS`=1.
- **Glitch rejection:** `PMOD[1]` low for 3 cycles, then high → `COUNT` stays 0, `CHANGED` never asserts, `EVENTS` unchanged.
- **Saturation:** perform 9 single presses and releases → `EVENTS` stops at 7. Then assert `CLEAR` in the same cycle as a press → `EVENTS`=0 on the next edge.
- **Release:** all three buttons pressed together → `EVENTS` +3 in one cycle. Release two of them → `COUNT` 3→1 with a single `CHANGED` pulse, and `EVENTS` unchanged.
- **Macro off:** press on edge t → `COUNT`=1 at t+2. Assert `RST_N` low mid-press → all outputs 0 immediately, with no clock needed.
